lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_pkg.sv | 37 +++
 rtl/lock_controller_if.sv | 30 +++
 rtl/lock_timer.sv | 25 ++
 rtl/lock_controller.sv | 195 +++++++++++++++++++
 tb/tb_lock_controller.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller and the code checker: state
// encoding, special key codes and compare-type codes.
package lock_pkg;

    typedef enum logic [3:0] {
        LOCKED,
        CHECK_UC,
        UNLOCKED,
        NEW1,
        STAGE,
        NEW2,
        CHECK_MATCH,
        LOCKOUT,
        CHECK_PC
    } state_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CHANGE = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [1:0] {
        CHK_PC    = 2'b00,   // compare against the master (PC) code
        CHK_UC    = 2'b01,   // compare against the user code
        CHK_MATCH = 2'b10,   // compare against the staged new user code
        CHK_STAGE = 2'b11    // stage the entered digits as the new user code
    } chk_type_t;

    // An entry needs at least this many digits before ENTER starts a compare.
    localparam logic [2:0] MIN_DIGITS = 3'd4;
    // Digit counter saturates here; longer entries are still forwarded.
    localparam logic [2:0] DIGIT_SAT  = 3'd6;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad / checker / status bundle of the lock controller.
// slave = controller side, master = keypad + checker + status consumer side.
interface lock_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       chk_done;
    logic       chk_correct;
    logic       chk_clear;
    logic       chk_digit_valid;
    logic [3:0] chk_digit;
    logic       chk_start;
    logic [1:0] chk_type;
    logic       uc_commit;
    logic       unlocked;
    logic       lockout;
    logic       busy;
    logic [1:0] fail_cnt;

    modport slave (
        input  key_valid, key_code, chk_done, chk_correct,
        output chk_clear, chk_digit_valid, chk_digit, chk_start, chk_type,
               uc_commit, unlocked, lockout, busy, fail_cnt
    );

    modport master (
        output key_valid, key_code, chk_done, chk_correct,
        input  chk_clear, chk_digit_valid, chk_digit, chk_start, chk_type,
               uc_commit, unlocked, lockout, busy, fail_cnt
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter. Counts to zero and holds there; expired is high
// while the count is zero. Shared between the unlock window and the
// compare timeout since the two never run at the same time.
module lock_timer #(
    parameter int W = 24
) (
    input  logic         hwclk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Reload wins; otherwise step down until zero.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (load)          cnt_q <= load_val;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock controller: collects digits, forwards them to an external
// code checker, sequences unlock / code-change / lockout flows.
module lock_controller
    import lock_pkg::*;
#(
    parameter int          MAX_FAIL      = 3,
    parameter logic [23:0] UNLOCK_CYCLES = 24'd12_000_000,
    parameter int          CHK_TIMEOUT   = 16
) (
    input  logic              hwclk,
    input  logic              rst,
    lock_controller_if.slave  bus
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic        post_rst_q;

    logic        clear_q, clear_d;
    logic        dv_q, dv_d;
    logic [3:0]  digit_q, digit_d;
    logic        start_q, start_d;
    logic [1:0]  type_q, type_d;
    logic        commit_q, commit_d;

    logic        tmr_load;
    logic [23:0] tmr_val;
    logic        tmr_expired;
    logic        res_vld, res_ok;

    lock_timer #(.W(24)) u_timer (
        .hwclk    (hwclk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // A compare resolves on chk_done, or as a wrong result once the timeout
    // runs out. The timer is loaded with CHK_TIMEOUT-1 so chk_done is still
    // honoured in the CHK_TIMEOUT-th cycle counting the chk_start cycle.
    assign res_vld = bus.chk_done || tmr_expired;
    assign res_ok  = bus.chk_done && bus.chk_correct;

    // State, counters and registered pulse outputs.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCKED;
            cnt_q      <= '0;
            fail_q     <= '0;
            post_rst_q <= 1'b1;
            clear_q    <= 1'b0;
            dv_q       <= 1'b0;
            digit_q    <= '0;
            start_q    <= 1'b0;
            type_q     <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            post_rst_q <= 1'b0;
            clear_q    <= clear_d;
            dv_q       <= dv_d;
            digit_q    <= digit_d;
            start_q    <= start_d;
            type_q     <= type_d;
            commit_q   <= commit_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        clear_d  = post_rst_q;   // one clear right after reset release
        dv_d     = 1'b0;
        digit_d  = digit_q;
        start_d  = 1'b0;
        type_d   = type_q;
        commit_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            LOCKED, NEW1, NEW2, LOCKOUT: begin
                if (bus.key_valid) begin
                    if (is_digit(bus.key_code)) begin
                        dv_d    = 1'b1;
                        digit_d = bus.key_code;
                        if (cnt_q < DIGIT_SAT) cnt_d = cnt_q + 3'd1;
                    end else if (bus.key_code == KEY_ENTER) begin
                        if (cnt_q >= MIN_DIGITS) begin
                            start_d  = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = 24'(CHK_TIMEOUT - 1);
                            case (state_q)
                                LOCKED:  begin state_d = CHECK_UC;    type_d = CHK_UC;    end
                                NEW1:    begin state_d = STAGE;       type_d = CHK_STAGE; end
                                NEW2:    begin state_d = CHECK_MATCH; type_d = CHK_MATCH; end
                                default: begin state_d = CHECK_PC;    type_d = CHK_PC;    end
                            endcase
                        end else begin
                            clear_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end else if (bus.key_code == KEY_CANCEL) begin
                        // Lockout can only be left through the PC, but
                        // CANCEL still discards the partial entry.
                        if (state_q != LOCKOUT) state_d = LOCKED;
                        clear_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end

            CHECK_UC: begin
                if (res_vld) begin
                    if (res_ok) begin
                        fail_d   = '0;
                        state_d  = UNLOCKED;
                        tmr_load = 1'b1;
                        tmr_val  = UNLOCK_CYCLES - 24'd1;
                    end else begin
                        fail_d  = fail_q + 2'd1;
                        state_d = (int'(fail_q) + 1 >= MAX_FAIL) ? LOCKOUT : LOCKED;
                    end
                end
            end

            UNLOCKED: begin
                if (bus.key_valid) begin
                    if (bus.key_code == KEY_CANCEL)      state_d = LOCKED;
                    else if (bus.key_code == KEY_CHANGE) state_d = NEW1;
                    else begin
                        tmr_load = 1'b1;
                        tmr_val  = UNLOCK_CYCLES - 24'd1;
                    end
                end else if (tmr_expired) begin
                    state_d = LOCKED;
                end
            end

            STAGE: begin
                if (res_vld) state_d = NEW2;
            end

            CHECK_MATCH: begin
                if (res_vld) begin
                    if (res_ok) begin
                        commit_d = 1'b1;
                        state_d  = UNLOCKED;
                        tmr_load = 1'b1;
                        tmr_val  = UNLOCK_CYCLES - 24'd1;
                    end else begin
                        state_d = NEW1;
                    end
                end
            end

            CHECK_PC: begin
                if (res_vld) begin
                    if (res_ok) begin
                        fail_d  = '0;
                        state_d = NEW1;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
            end

            default: state_d = LOCKED;
        endcase

        // Every state change starts the checker and the digit count afresh.
        if (state_d != state_q) begin
            clear_d = 1'b1;
            cnt_d   = '0;
        end
    end

    assign bus.chk_clear       = clear_q;
    assign bus.chk_digit_valid = dv_q;
    assign bus.chk_digit       = digit_q;
    assign bus.chk_start       = start_q;
    assign bus.chk_type        = type_q;
    assign bus.uc_commit       = commit_q;
    assign bus.fail_cnt        = fail_q;
    assign bus.unlocked        = (state_q == UNLOCKED);
    assign bus.lockout         = (state_q == LOCKOUT) || (state_q == CHECK_PC);
    assign bus.busy            = state_q inside {CHECK_UC, STAGE, CHECK_MATCH, CHECK_PC};

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a cycle-level reference model of
// the keypad lock behaviour and a per-cycle output compare.
module tb_lock_controller;
    import lock_pkg::*;

    localparam int          MAXF = 3;
    localparam logic [23:0] UNL  = 24'd40;
    localparam int          TMO  = 16;

    logic hwclk = 1'b0;
    logic rst   = 1'b1;

    lock_controller_if bus();

    lock_controller #(
        .MAX_FAIL      (MAXF),
        .UNLOCK_CYCLES (UNL),
        .CHK_TIMEOUT   (TMO)
    ) dut (
        .hwclk (hwclk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 hwclk = ~hwclk;

    int n_vec = 0;
    int n_bad = 0;
    int commits = 0;
    int fwd = 0;
    int clears = 0;

    // Reference model: what the entry is for (0 user code, 1 new code,
    // 2 confirm new code, 3 master code), whether the lock is open, whether
    // a compare is outstanding, and the counters around them.
    int   entry, digits, age, open_left, fails;
    bit   open, waiting, first, ok;
    logic m_clear, m_dv, m_start, m_commit;
    logic [3:0] m_digit;
    logic [1:0] m_type;

    function automatic logic [1:0] type_for(input int e);
        case (e)
            0:       return 2'b01;
            1:       return 2'b11;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        entry = 0; digits = 0; age = 0; open_left = 0; fails = 0;
        open = 0; waiting = 0; first = 1;
        m_clear = 0; m_dv = 0; m_start = 0; m_commit = 0; m_digit = '0; m_type = '0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_clear = first; first = 0;
        m_dv = 0; m_start = 0; m_commit = 0;
        if (waiting) begin
            age++;
            if (bus.chk_done || age >= TMO) begin
                ok = bus.chk_done && bus.chk_correct;
                waiting = 0; m_clear = 1; digits = 0;
                case (entry)
                    0: if (ok) begin fails = 0; open = 1; open_left = int'(UNL); end
                       else begin fails++; if (fails >= MAXF) entry = 3; end
                    1: entry = 2;
                    2: if (ok) begin m_commit = 1; open = 1; open_left = int'(UNL); entry = 0; end
                       else entry = 1;
                    default: if (ok) begin fails = 0; entry = 1; end
                endcase
            end
        end else if (open) begin
            if (bus.key_valid && bus.key_code == KEY_CANCEL) begin
                open = 0; entry = 0; m_clear = 1; digits = 0;
            end else if (bus.key_valid && bus.key_code == KEY_CHANGE) begin
                open = 0; entry = 1; m_clear = 1; digits = 0;
            end else if (bus.key_valid) begin
                open_left = int'(UNL);
            end else begin
                open_left--;
                if (open_left == 0) begin open = 0; entry = 0; m_clear = 1; digits = 0; end
            end
        end else if (bus.key_valid) begin
            if (bus.key_code <= 4'd9) begin
                m_dv = 1; m_digit = bus.key_code;
                if (digits < 6) digits++;
            end else if (bus.key_code == KEY_ENTER) begin
                m_clear = 1;
                if (digits >= 4) begin
                    waiting = 1; age = 0; m_start = 1; m_type = type_for(entry);
                end
                digits = 0;
            end else if (bus.key_code == KEY_CANCEL) begin
                m_clear = 1; digits = 0;
                if (entry != 3) entry = 0;
            end
        end
    endtask

    function automatic logic [14:0] dut_out();
        return {bus.chk_clear, bus.chk_digit_valid, bus.chk_digit, bus.chk_start, bus.chk_type,
                bus.uc_commit, bus.unlocked, bus.lockout, bus.busy, bus.fail_cnt};
    endfunction

    function automatic logic [14:0] model_out();
        return {m_clear, m_dv, m_digit, m_start, m_type, m_commit,
                open, (entry == 3) && !open, waiting, 2'(fails)};
    endfunction

    task automatic cmp_model();
        logic [14:0] a, e;
        a = dut_out();
        e = model_out();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL cycle t=%0t {clr,dv,dig,start,type,commit,unl,lko,busy,fail} got %b required %b",
                     $time, a, e);
        end
        if (bus.uc_commit)       commits++;
        if (bus.chk_digit_valid) fwd++;
        if (bus.chk_clear)       clears++;
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_vec++;
        if (actual != required) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // One cycle: compare on the falling edge, advance the model on the
    // rising edge, then leave the inputs settable 2 time units later.
    task automatic tick();
        @(negedge hwclk);
        cmp_model();
        @(posedge hwclk);
        model_step();
        #2;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic code4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic resolve(input logic correct, input int dly);
        repeat (dly) tick();
        bus.chk_done    = 1'b1;
        bus.chk_correct = correct;
        tick();
        bus.chk_done    = 1'b0;
        bus.chk_correct = 1'b0;
    endtask

    initial begin
        int n, c0;
        model_reset();
        bus.key_valid = 1'b0; bus.key_code = '0;
        bus.chk_done  = 1'b0; bus.chk_correct = 1'b0;

        // Reset state and the single clear after release.
        repeat (3) tick();
        check("rst_outputs", int'(dut_out()), 0);
        rst = 1'b0;
        c0 = clears;
        repeat (4) tick();
        check("post_rst_clear", clears - c0, 1);

        // Correct user code, checker answers three cycles after chk_start.
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        check("uc_start", int'(bus.chk_start), 1);
        check("uc_type", int'(bus.chk_type), 1);
        check("uc_busy", int'(bus.busy), 1);
        resolve(1'b1, 3);
        check("unlock_next", int'(bus.unlocked), 1);
        n = 0;
        for (int i = 0; i < 200 && bus.unlocked; i++) begin
            n++;
            tick();
        end
        check("unlock_len", n, 40);

        // Three digits then ENTER: no compare, just a clear.
        press(4'd1); press(4'd2); press(4'd3);
        press(KEY_ENTER);
        check("short_nostart", int'(bus.chk_start), 0);
        check("short_clear", int'(bus.chk_clear), 1);
        check("short_busy", int'(bus.busy), 0);

        // Three wrong user codes lead to lockout.
        for (int i = 1; i <= 3; i++) begin
            code4(4'd1, 4'd1, 4'd1, 4'd1);
            press(KEY_ENTER);
            resolve(1'b0, 2);
            if (i < 3) begin
                check("fail_cnt", int'(bus.fail_cnt), i);
                check("no_lockout_yet", int'(bus.lockout), 0);
            end else begin
                check("lockout", int'(bus.lockout), 1);
            end
        end
        code4(4'd9, 4'd9, 4'd9, 4'd9);
        press(KEY_ENTER);
        check("pc_type", int'(bus.chk_type), 0);
        resolve(1'b1, 1);
        check("pc_lockout_clr", int'(bus.lockout), 0);
        check("pc_fail_clr", int'(bus.fail_cnt), 0);
        code4(4'd5, 4'd5, 4'd5, 4'd5);
        press(KEY_ENTER);
        check("pc_to_new1_type", int'(bus.chk_type), 3);
        resolve(1'b0, 1);
        press(KEY_CANCEL);
        tick();

        // Code change flow.
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        resolve(1'b1, 2);
        press(4'd7);                  // restarts the unlock window
        press(KEY_CHANGE);
        check("change_relocks", int'(bus.unlocked), 0);
        code4(4'd5, 4'd5, 4'd5, 4'd5);
        press(KEY_ENTER);
        check("stage_type", int'(bus.chk_type), 3);
        resolve(1'b1, 1);
        c0 = commits;
        code4(4'd5, 4'd5, 4'd5, 4'd5);
        press(KEY_ENTER);
        check("match_type", int'(bus.chk_type), 2);
        resolve(1'b1, 3);
        check("commit_unlocked", int'(bus.unlocked), 1);
        repeat (3) tick();
        check("uc_commit_once", commits - c0, 1);
        press(KEY_CANCEL);
        tick();

        // Checker never answers: timeout counts as a wrong code.
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        repeat (15) tick();
        check("pre_timeout_busy", int'(bus.busy), 1);
        tick();
        check("timeout_fail", int'(bus.fail_cnt), 1);
        check("timeout_idle", int'(bus.busy), 0);

        // A key arriving with chk_done is dropped.
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        repeat (2) tick();
        c0 = fwd;
        bus.chk_done = 1'b1; bus.chk_correct = 1'b0;
        bus.key_valid = 1'b1; bus.key_code = 4'd7;
        tick();
        bus.chk_done = 1'b0; bus.key_valid = 1'b0;
        repeat (2) tick();
        check("coincident_key_dropped", fwd - c0, 0);
        check("coincident_fail", int'(bus.fail_cnt), 2);

        // Reset while a compare is outstanding.
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        tick();
        check("busy_before_rst", int'(bus.busy), 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_outputs", int'(dut_out()), 0);
        repeat (2) tick();
        rst = 1'b0;
        c0 = clears;
        repeat (4) tick();
        check("post_rst_clear2", clears - c0, 1);
        check("post_rst_fail", int'(bus.fail_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
